// File: rtl/mycpu_mem_stage.sv
// Memory-access pipeline stage: latches the execute result, issues at most one
// data-memory request per instruction, aligns load data and hands one result to write-back.
module mycpu_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic [31:0] es_result,
    input  logic        es_ovf,
    input  logic [3:0]  es_mem_op,
    input  logic [31:0] es_store_data,
    input  logic [4:0]  es_dest,
    output logic        ms_allowin,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    input  logic        wb_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_result,
    output logic [4:0]  ms_dest,
    output logic [1:0]  ms_exc
);

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                           OP_LHU  = 4'd4, OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7,
                           OP_SW   = 4'd8;
    localparam logic [1:0] EXC_NONE = 2'd0, EXC_OVF = 2'd1, EXC_ADEL = 2'd2, EXC_ADES = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_SW:         return 2'd2;
            default:              return 2'd0;
        endcase
    endfunction

    state_e      state_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q, sdata_q, result_q;
    logic [4:0]  dest_q;
    logic [1:0]  exc_q;

    logic [3:0]  op_d;
    logic [4:0]  dest_d;
    logic [1:0]  exc_d;
    logic        misalign, go_mem_d, accept;
    logic [31:0] shifted, load_data_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_d     = (es_mem_op > OP_SW) ? OP_NONE : es_mem_op;
        misalign = ((op_size(op_d) == 2'd1) && es_result[0]) ||
                   ((op_size(op_d) == 2'd2) && (es_result[1:0] != 2'b00));
        exc_d    = EXC_NONE;
        if (es_ovf)        exc_d = EXC_OVF;
        else if (misalign) exc_d = is_store(op_d) ? EXC_ADES : EXC_ADEL;
        dest_d   = ((exc_d != EXC_NONE) || is_store(op_d)) ? 5'd0 : es_dest;
        go_mem_d = (is_load(op_d) || is_store(op_d)) && (exc_d == EXC_NONE);
    end

    // Request fields come straight from the latched instruction, so they stay
    // stable for as long as the request waits for addr_ok.
    always_comb begin
        data_wr    = is_store(op_q);
        data_size  = op_size(op_q);
        data_addr  = addr_q;
        data_wstrb = 4'b0000;
        data_wdata = 32'd0;
        case (op_q)
            OP_SB: begin
                data_wstrb = 4'b0001 << addr_q[1:0];
                data_wdata = {4{sdata_q[7:0]}};
            end
            OP_SH: begin
                data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{sdata_q[15:0]}};
            end
            OP_SW: begin
                data_wstrb = 4'b1111;
                data_wdata = sdata_q;
            end
            default: ;
        endcase
    end

    // Halves are known to be aligned here, so one byte-granular shift serves both widths.
    always_comb begin
        shifted = data_rdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            OP_LB:   load_data_d = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data_d = {24'd0, shifted[7:0]};
            OP_LH:   load_data_d = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data_d = {16'd0, shifted[15:0]};
            OP_LW:   load_data_d = data_rdata;
            default: load_data_d = addr_q;
        endcase
    end

    assign ms_allowin     = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_allowin);
    assign accept         = es_valid && ms_allowin && !flush;
    assign data_req       = (state_q == S_REQ);
    assign ms_to_ws_valid = (state_q == S_DONE);
    assign ms_result      = result_q;
    assign ms_dest        = dest_q;
    assign ms_exc         = exc_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NONE;
            addr_q   <= 32'd0;
            sdata_q  <= 32'd0;
            result_q <= 32'd0;
            dest_q   <= 5'd0;
            exc_q    <= EXC_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q     <= op_d;
                        addr_q   <= es_result;
                        sdata_q  <= es_store_data;
                        result_q <= es_result;
                        dest_q   <= dest_d;
                        exc_q    <= exc_d;
                        state_q  <= go_mem_d ? S_REQ : S_DONE;
                    end else if (flush || ms_allowin) begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (flush)             state_q <= data_addr_ok ? S_DRAIN : S_IDLE;
                    else if (data_addr_ok) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A flush coinciding with the response has nothing left to drain.
                    if (data_data_ok) begin
                        state_q <= flush ? S_IDLE : S_DONE;
                        if (!flush) result_q <= load_data_d;
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (data_data_ok) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// Directed and randomized checks of mycpu_mem_stage against a byte-level memory
// reference model.
module tb_mycpu_mem_stage;

    logic        clk = 1'b0;
    logic        reset, es_valid, es_ovf, flush;
    logic [31:0] es_result, es_store_data, data_rdata;
    logic [3:0]  es_mem_op;
    logic [4:0]  es_dest;
    logic        data_addr_ok, data_data_ok, wb_allowin;
    logic        ms_allowin, data_req, data_wr, ms_to_ws_valid;
    logic [1:0]  data_size, ms_exc;
    logic [31:0] data_addr, data_wdata, ms_result;
    logic [3:0]  data_wstrb;
    logic [4:0]  ms_dest;

    always #5 clk = ~clk;

    mycpu_mem_stage dut (
        .clk(clk), .reset(reset), .es_valid(es_valid), .es_result(es_result),
        .es_ovf(es_ovf), .es_mem_op(es_mem_op), .es_store_data(es_store_data),
        .es_dest(es_dest), .ms_allowin(ms_allowin), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
        .data_data_ok(data_data_ok), .wb_allowin(wb_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_result(ms_result),
        .ms_dest(ms_dest), .ms_exc(ms_exc)
    );

    localparam logic [31:0] BASE = 32'h0000_8000;
    localparam int N_RAND = 300;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic [1:0]  exc;
        bit          mem;
    } exp_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_bus [64];
    logic [7:0] mem_ref [64];
    exp_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Reference: little-endian byte memory, sizes and sign rules applied arithmetically.
    function automatic exp_t ref_exec(input int op_in, input logic [31:0] addr, input logic ovf,
                                      input logic [31:0] sd, input logic [4:0] dest);
        exp_t e;
        int op, nbytes, idx;
        bit ld, st, sgn;
        longint val;
        op     = (op_in > 8) ? 0 : op_in;
        ld     = (op >= 1) && (op <= 5);
        st     = (op >= 6) && (op <= 8);
        sgn    = (op == 1) || (op == 3);
        nbytes = (op == 1 || op == 2 || op == 6) ? 1 :
                 (op == 3 || op == 4 || op == 7) ? 2 :
                 (op == 5 || op == 8) ? 4 : 0;
        if (ovf)                                          e.exc = 2'd1;
        else if (nbytes > 1 && (int'(addr[1:0]) % nbytes) != 0) e.exc = st ? 2'd3 : 2'd2;
        else                                              e.exc = 2'd0;
        e.res  = addr;
        e.dest = (e.exc != 0 || st) ? 5'd0 : dest;
        e.mem  = (ld || st) && (e.exc == 0);
        if (e.mem) begin
            idx = int'(addr - BASE);
            if (st) begin
                for (int i = 0; i < nbytes; i++) mem_ref[idx + i] = sd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < nbytes; i++) val = val | (longint'(mem_ref[idx + i]) << (8 * i));
                if (sgn && val >= (longint'(1) << (8 * nbytes - 1))) val = val - (longint'(1) << (8 * nbytes));
                e.res = val[31:0];
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic ovf,
                         input logic [31:0] sd, input logic [4:0] d);
        es_valid = 1'b1; es_mem_op = op; es_result = a; es_ovf = ovf;
        es_store_data = sd; es_dest = d;
        @(negedge clk);
        es_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] a, input int aok_delay, input logic [31:0] rd);
        for (int i = 0; i < aok_delay; i++) begin
            check("req_held", data_req, 1);
            check("addr_stable", data_addr, a);
            @(negedge clk);
        end
        check("req_up", data_req, 1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rd;
        @(negedge clk);
        data_data_ok = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic [4:0] d,
                             input logic [1:0] exc);
        check({tag, "_valid"}, ms_to_ws_valid, 1);
        check({tag, "_result"}, ms_result, res);
        check({tag, "_dest"}, ms_dest, d);
        check({tag, "_exc"}, ms_exc, exc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    logic [3:0]  r_op;
    logic [31:0] r_addr, r_sd, bus_addr, bus_wdata;
    logic        r_ovf, bus_wr, do_accept, aok, dok;
    logic [3:0]  bus_wstrb;
    logic [4:0]  r_dest;
    bit          have, pend, cur_mem;
    int          issued, done_cnt, cyc, pend_wait, pw, aw;
    exp_t        e, got;

    initial begin
        reset = 1'b1; es_valid = 1'b0; es_result = 32'd0; es_ovf = 1'b0; es_mem_op = 4'd0;
        es_store_data = 32'd0; es_dest = 5'd0; flush = 1'b0; data_addr_ok = 1'b0;
        data_rdata = 32'd0; data_data_ok = 1'b0; wb_allowin = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem_bus[i] = 8'($urandom);
            mem_ref[i] = mem_bus[i];
        end
        repeat (2) @(negedge clk);
        check("rst_valid", ms_to_ws_valid, 0);
        check("rst_req", data_req, 0);
        check("rst_wr", data_wr, 0);
        check("rst_wstrb", data_wstrb, 0);
        check("rst_size", data_size, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_result", ms_result, 0);
        check("rst_dest", ms_dest, 0);
        check("rst_exc", ms_exc, 0);
        check("rst_allowin", ms_allowin, 1);
        reset = 1'b0;
        @(negedge clk);

        // Non-memory op: valid the cycle after accept, never a request.
        issue(4'd0, 32'h0000_1234, 1'b0, 32'd0, 5'd5);
        check_out("add", 32'h1234, 5'd5, 2'd0);
        check("add_noreq", data_req, 0);
        @(negedge clk);
        check("add_idle", ms_to_ws_valid, 0);

        // Byte store: lane replication and strobe, valid three cycles after accept.
        issue(4'd6, 32'h0000_1003, 1'b0, 32'h0000_00AB, 5'd9);
        check("sb_req", data_req, 1);
        check("sb_wr", data_wr, 1);
        check("sb_wstrb", data_wstrb, 4'b1000);
        check("sb_wdata", data_wdata, 32'hABAB_ABAB);
        check("sb_size", data_size, 0);
        check("sb_addr", data_addr, 32'h1003);
        check("sb_valid_n1", ms_to_ws_valid, 0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        check("sb_req_drop", data_req, 0);
        check("sb_valid_n2", ms_to_ws_valid, 0);
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        check_out("sb", 32'h1003, 5'd0, 2'd0);

        // Loads: sub-word select and extension; each issue overlaps the previous DONE.
        issue(4'd1, 32'h0000_2001, 1'b0, 32'd0, 5'd7);
        check("lb_wstrb", data_wstrb, 0);
        check("lb_wr", data_wr, 0);
        serve(32'h2001, 3, 32'h1234_80FF);
        check_out("lb", 32'hFFFF_FF80, 5'd7, 2'd0);
        issue(4'd2, 32'h0000_2001, 1'b0, 32'd0, 5'd7);
        serve(32'h2001, 1, 32'h1234_80FF);
        check_out("lbu", 32'h0000_0080, 5'd7, 2'd0);
        issue(4'd4, 32'h0000_2002, 1'b0, 32'd0, 5'd8);
        check("lhu_size", data_size, 1);
        serve(32'h2002, 0, 32'h1234_80FF);
        check_out("lhu", 32'h0000_1234, 5'd8, 2'd0);
        issue(4'd3, 32'h0000_2000, 1'b0, 32'd0, 5'd8);
        serve(32'h2000, 0, 32'h1234_80FF);
        check_out("lh", 32'hFFFF_80FF, 5'd8, 2'd0);
        issue(4'd5, 32'h0000_2004, 1'b0, 32'd0, 5'd10);
        check("lw_size", data_size, 2);
        serve(32'h2004, 2, 32'hDEAD_BEEF);
        check_out("lw", 32'hDEAD_BEEF, 5'd10, 2'd0);

        // Exceptions never reach the bus; overflow outranks the address error.
        issue(4'd5, 32'h0000_3002, 1'b0, 32'd0, 5'd9);
        check("adel_exc", ms_exc, 2);
        check("adel_dest", ms_dest, 0);
        check("adel_noreq", data_req, 0);
        issue(4'd7, 32'h0000_3001, 1'b0, 32'h55, 5'd9);
        check("ades_exc", ms_exc, 3);
        check("ades_noreq", data_req, 0);
        issue(4'd8, 32'h0000_3003, 1'b1, 32'h55, 5'd9);
        check("ovf_exc", ms_exc, 1);
        check("ovf_dest", ms_dest, 0);
        check("ovf_noreq", data_req, 0);
        issue(4'd0, 32'h0000_0077, 1'b1, 32'd0, 5'd9);
        check("ovf_alu_exc", ms_exc, 1);
        check("ovf_alu_dest", ms_dest, 0);
        @(negedge clk);

        // Flush beats a same-cycle accept.
        es_valid = 1'b1; es_mem_op = 4'd0; es_result = 32'h99; es_dest = 5'd1; flush = 1'b1;
        @(negedge clk);
        es_valid = 1'b0; flush = 1'b0;
        check("flush_acc_valid", ms_to_ws_valid, 0);
        check("flush_acc_allowin", ms_allowin, 1);

        // Flush in REQ before addr_ok withdraws the request.
        issue(4'd5, 32'h0000_4000, 1'b0, 32'd0, 5'd3);
        check("fr_req", data_req, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fr_req_gone", data_req, 0);
        check("fr_valid", ms_to_ws_valid, 0);
        check("fr_allowin", ms_allowin, 1);

        // Flush in WAIT drains the response, then the next load is unaffected.
        issue(4'd5, 32'h0000_4000, 1'b0, 32'd0, 5'd3);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_allowin", ms_allowin, 0);
        check("drain_valid", ms_to_ws_valid, 0);
        check("drain_req", data_req, 0);
        @(negedge clk);
        check("drain_hold", ms_allowin, 0);
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        @(negedge clk);
        data_data_ok = 1'b0;
        check("drain_done_allowin", ms_allowin, 1);
        check("drain_done_valid", ms_to_ws_valid, 0);
        issue(4'd5, 32'h0000_4004, 1'b0, 32'd0, 5'd3);
        serve(32'h4004, 0, 32'hCAFE_BABE);
        check_out("post_drain", 32'hCAFE_BABE, 5'd3, 2'd0);
        @(negedge clk);

        // Write-back stall holds the result, then back-to-back accept with no bubble.
        wb_allowin = 1'b0;
        issue(4'd0, 32'h0000_00A1, 1'b0, 32'd0, 5'd4);
        es_valid = 1'b1; es_mem_op = 4'd0; es_result = 32'h0000_00B2; es_dest = 5'd6;
        for (int i = 0; i < 4; i++) begin
            check_out("stall", 32'hA1, 5'd4, 2'd0);
            check("stall_allowin", ms_allowin, 0);
            @(negedge clk);
        end
        wb_allowin = 1'b1;
        #1;
        check("b2b_allowin", ms_allowin, 1);
        @(negedge clk);
        es_valid = 1'b0;
        check_out("b2b", 32'hB2, 5'd6, 2'd0);
        @(negedge clk);
        check("b2b_idle", ms_to_ws_valid, 0);

        // Asynchronous reset in the middle of a request.
        issue(4'd5, 32'h0000_5000, 1'b0, 32'd0, 5'd2);
        check("arst_pre_req", data_req, 1);
        reset = 1'b1;
        #1;
        check("arst_req", data_req, 0);
        check("arst_allowin", ms_allowin, 1);
        check("arst_addr", data_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Randomized traffic against the reference model and a behavioural memory.
        have = 0; pend = 0; cur_mem = 0; issued = 0; done_cnt = 0; cyc = 0; pw = 0; pend_wait = 0;
        while (done_cnt < N_RAND && cyc < 30000) begin
            cyc++;
            if (!have && issued < N_RAND && $urandom_range(0, 3) != 0) begin
                r_op   = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 4) == 0) r_op = 4'd0;
                r_addr = (r_op >= 4'd1 && r_op <= 4'd8) ? BASE + 32'($urandom_range(0, 63)) : $urandom();
                r_ovf  = ($urandom_range(0, 11) == 0);
                r_sd   = $urandom();
                r_dest = 5'($urandom_range(0, 31));
                have   = 1;
            end
            es_valid = have; es_mem_op = r_op; es_result = r_addr; es_ovf = r_ovf;
            es_store_data = r_sd; es_dest = r_dest;
            wb_allowin   = ($urandom_range(0, 3) != 0);
            data_data_ok = pend && (pend_wait == 0);
            data_rdata   = data_data_ok ? {mem_bus[pw*4+3], mem_bus[pw*4+2], mem_bus[pw*4+1], mem_bus[pw*4]}
                                        : $urandom();
            #1;
            data_addr_ok = data_req && !pend && ($urandom_range(0, 2) != 0);
            if (data_req) check("rand_req_legal", 32'(cur_mem), 1);
            if (ms_to_ws_valid && wb_allowin) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious_valid", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    if (got.exc == 2'd0) check("rand_result", ms_result, got.res);
                    check("rand_dest", ms_dest, got.dest);
                    check("rand_exc", ms_exc, got.exc);
                end
                done_cnt++;
            end
            do_accept = es_valid && ms_allowin;
            aok = data_addr_ok && data_req;
            dok = data_data_ok;
            bus_wr = data_wr; bus_addr = data_addr; bus_wstrb = data_wstrb; bus_wdata = data_wdata;
            @(posedge clk);
            if (do_accept) begin
                e = ref_exec(int'(r_op), r_addr, r_ovf, r_sd, r_dest);
                exp_q.push_back(e);
                cur_mem = e.mem;
                have = 0;
                issued++;
            end
            if (dok) pend = 0;
            else if (pend && pend_wait > 0) pend_wait--;
            if (aok) begin
                aw = int'((bus_addr - BASE) >> 2);
                if (aw < 0 || aw > 15) aw = 0;
                pend = 1; pw = aw; pend_wait = $urandom_range(0, 2);
                if (bus_wr) begin
                    for (int i = 0; i < 4; i++)
                        if (bus_wstrb[i]) mem_bus[aw*4+i] = bus_wdata[8*i +: 8];
                end
            end
            @(negedge clk);
        end
        es_valid = 1'b0;
        check("rand_completed", done_cnt, N_RAND);
        check("rand_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
